// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } ccff_state_t;

    // Host words needed to fill a chain of len flops, w bits per word.
    function automatic int ccff_words(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

    function automatic int ccff_err_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out word register; MSB leaves first.
module ccff_piso
    import ccff_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/ccff_loader.sv
// Driving end of the ccff_head -> ccff_tail configuration chain, with optional
// read-back compare pass.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_FETCH | s_ready high, chain clock gated off, waiting for a word
//   ST_SHIFT | chain clock on, one word bit per cycle onto ccff_head
//   ST_FIN   | done pulse cycle, back to idle
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 31,
    parameter int DATA_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset_n,
    input  logic                           start,
    input  logic                           verify,
    input  logic [DATA_W-1:0]              s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           ccff_head,
    output logic                           ccff_clk_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] err_cnt,
    output logic                           pass
);

    localparam int ERR_W = ccff_err_w(CHAIN_LEN);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(DATA_W + 1);

    ccff_state_t       state;
    logic              verify_q;
    logic              pass_idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_inc;
    logic [WB_W-1:0]   word_bits;
    logic [WB_W-1:0]   fetch_bits;
    logic              handshake;
    logic              mismatch;
    logic [ERR_W-1:0]  err_nxt;

    assign handshake   = (state == ST_FETCH) && s_valid && s_ready;
    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign mismatch    = (state == ST_SHIFT) && pass_idx && (ccff_tail != ccff_head);
    assign err_nxt     = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

    // The last word of a pass may only partly fit; its low bits are never shifted.
    always_comb begin
        fetch_bits = WB_W'(DATA_W);
        if ((CHAIN_LEN - int'(bit_cnt)) < DATA_W)
            fetch_bits = WB_W'(CHAIN_LEN - int'(bit_cnt));
    end

    ccff_piso #(.DATA_W(DATA_W)) u_piso (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .load         (handshake),
        .shift        (state == ST_SHIFT),
        .din          (s_data),
        .msb          (ccff_head)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state       <= ST_IDLE;
            verify_q    <= 1'b0;
            pass_idx    <= 1'b0;
            bit_cnt     <= '0;
            word_bits   <= '0;
            s_ready     <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_cnt     <= '0;
            pass        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        verify_q <= verify;
                        bit_cnt  <= '0;
                        pass_idx <= 1'b0;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (handshake) begin
                        s_ready     <= 1'b0;
                        word_bits   <= fetch_bits;
                        ccff_clk_en <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt   <= bit_cnt_inc;
                    word_bits <= word_bits - WB_W'(1);
                    err_cnt   <= err_nxt;
                    if (word_bits == WB_W'(1)) begin
                        ccff_clk_en <= 1'b0;
                        if (bit_cnt_inc < CNT_W'(CHAIN_LEN)) begin
                            s_ready <= 1'b1;
                            state   <= ST_FETCH;
                        end else if (verify_q && !pass_idx) begin
                            pass_idx <= 1'b1;
                            bit_cnt  <= '0;
                            s_ready  <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed plus randomized bench for ccff_loader against a behavioural chain
// and a bit-stream reference of what the chain must end up holding.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int CHAIN_LEN = 31;
    localparam int DATA_W    = 8;
    localparam int ERR_W     = $clog2(CHAIN_LEN + 1);
    localparam int NWORDS    = ccff_words(CHAIN_LEN, DATA_W);

    logic              prog_clk = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start = 1'b0;
    logic              verify = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_cnt;
    logic              pass;

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .verify       (verify),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_clk_en  (ccff_clk_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .err_cnt      (err_cnt),
        .pass         (pass)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: flop 0 takes ccff_head, flop CHAIN_LEN-1 is the tail.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] nxt_chain;
    int en_cnt = 0, cyc = 0, last_en_cyc = 0, done_cnt = 0, done_cyc = 0;
    int corrupt_at = -1;
    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ccff_clk_en) begin
            en_cnt++;
            last_en_cyc = cyc;
            nxt_chain = {chain[CHAIN_LEN-2:0], ccff_head};
            // single upset: flop 10 reads 0 once the first pass has landed
            if (en_cnt == corrupt_at) nxt_chain[10] = 1'b0;
            chain <= nxt_chain;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [DATA_W-1:0] wq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream bit k is bit DATA_W-1-(k mod DATA_W) of word k/DATA_W; after a
    // full pass the first-shifted bit sits at the tail.
    function automatic logic [CHAIN_LEN-1:0] exp_image();
        logic [CHAIN_LEN-1:0] img;
        logic [DATA_W-1:0] w;
        img = '0;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            w = wq[k / DATA_W];
            img[CHAIN_LEN-1-k] = w[DATA_W-1-(k % DATA_W)];
        end
        return img;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":ctl"}, {s_ready, ccff_head, ccff_clk_en, busy, done, pass}, 6'b0);
        chk({tag, ":err_cnt"}, err_cnt, 0);
    endtask

    task automatic wait_ready(input string tag);
        int budget;
        budget = 0;
        while (!s_ready && budget < 40) begin
            @(posedge prog_clk); #1;
            budget++;
        end
        chk({tag, ":fetch_ready"}, s_ready, 1);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge prog_clk); #1;
        s_valid = 1'b0;
        s_data  = DATA_W'($urandom);
    endtask

    task automatic do_load(input bit vfy, input int stall_word, input int stall_len,
                           input bit poke, input bit corrupt, input string tag);
        logic [CHAIN_LEN-1:0] img;
        int en0, d0, budget, exp_err, passes;
        img     = exp_image();
        exp_err = (corrupt && vfy) ? int'(img[10]) : 0;
        passes  = vfy ? 2 : 1;
        en0 = en_cnt;
        d0  = done_cnt;
        corrupt_at = corrupt ? en0 + CHAIN_LEN : -1;

        start = 1'b1; verify = vfy;
        @(posedge prog_clk); #1;
        start = 1'b0; verify = 1'b0;
        chk({tag, ":ready_busy"}, {s_ready, busy}, 2'b11);

        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < NWORDS; i++) begin
                wait_ready(tag);
                if (p == 0 && i == stall_word) begin
                    for (int c = 0; c < stall_len; c++) begin
                        chk({tag, ":stall_clk_en"}, ccff_clk_en, 0);
                        @(posedge prog_clk); #1;
                    end
                end
                send_word(wq[i]);
                if (poke && p == 0 && i == 0) begin
                    start = 1'b1; verify = 1'b1;
                    @(posedge prog_clk); #1;
                    start = 1'b0; verify = 1'b0;
                end
            end
        end

        budget = 0;
        while (done_cnt == d0 && budget < 100) begin
            @(posedge prog_clk); #1;
            budget++;
        end
        chk({tag, ":done_seen"}, done_cnt - d0, 1);
        chk({tag, ":enables"}, en_cnt - en0, CHAIN_LEN * passes);
        chk({tag, ":done_latency"}, done_cyc - last_en_cyc, 1);
        chk({tag, ":chain"}, chain, img);
        chk({tag, ":err_cnt"}, err_cnt, exp_err);
        chk({tag, ":pass"}, pass, (exp_err == 0));
        chk({tag, ":idle_after"}, {busy, done, ccff_clk_en}, 3'b0);
        repeat (3) @(posedge prog_clk);
        #1;
        chk({tag, ":single_done"}, done_cnt - d0, 1);
        chk({tag, ":pass_hold"}, pass, (exp_err == 0));
        corrupt_at = -1;
    endtask

    initial begin
        int en0, d0, budget;

        repeat (3) @(posedge prog_clk);
        #1;
        chk_reset_outputs("reset");
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;

        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h81};
        do_load(1'b0, -1, 0, 1'b0, 1'b0, "plain");
        do_load(1'b1, -1, 0, 1'b0, 1'b0, "verify_clean");

        wq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(1'b1, -1, 0, 1'b0, 1'b1, "verify_corrupt");

        wq = '{8'hA5, 8'h3C, 8'hFF, 8'h81};
        do_load(1'b0, 2, 5, 1'b0, 1'b0, "stall");
        do_load(1'b0, -1, 0, 1'b1, 1'b0, "ignored_start");

        // abort after 12 shifts
        en0 = en_cnt;
        d0  = done_cnt;
        start = 1'b1; verify = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b0;
        wait_ready("abort");
        send_word(wq[0]);
        wait_ready("abort");
        send_word(wq[1]);
        budget = 0;
        while ((en_cnt - en0) < 12 && budget < 40) begin
            @(posedge prog_clk); #1;
            budget++;
        end
        chk("abort:shifts_before_reset", en_cnt - en0, 12);
        prog_reset_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (3) @(posedge prog_clk);
        #1;
        chk("abort:no_more_shifts", en_cnt - en0, 12);
        chk("abort:no_done", done_cnt - d0, 0);
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;
        do_load(1'b0, -1, 0, 1'b0, 1'b0, "after_reset");

        for (int r = 0; r < 4; r++) begin
            wq = {};
            for (int i = 0; i < NWORDS; i++) wq.push_back(DATA_W'($urandom));
            do_load(r[0], $urandom_range(0, NWORDS - 1), $urandom_range(0, 4),
                    1'b0, (r == 3), $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
